// File: rtl/fetch_sequencer_if.sv
// Handshake bundle between the fetch sequencer, its program ROM and the processor.
// The master modport is the sequencer side; slave is the ROM/processor side.
interface fetch_sequencer_if;
  logic       start;
  logic       step;
  logic       done;
  logic [8:0] rom_data;
  logic [4:0] ADDRESS;
  logic       run;
  logic       busy;
  logic       halted;
  logic [7:0] instr_count;

  modport master (
    input  start, step, done, rom_data,
    output ADDRESS, run, busy, halted, instr_count
  );

  modport slave (
    output start, step, done, rom_data,
    input  ADDRESS, run, busy, halted, instr_count
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Program fetch sequencer: walks a synchronous ROM, issues one run pulse per
// instruction, skips immediate words. Optional macro: FETCH_SINGLE_STEP_EN.
module fetch_sequencer #(
  parameter logic [4:0] LAST_ADDR  = 5'd31,
  parameter logic [2:0] IMM_OPCODE = 3'b001
) (
  input logic              clk,
  input logic              resetn,
  fetch_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_ROM,
    ISSUE,
    IMM,
    EXEC,
    ADVANCE,
    HALT
  } state_e;

  state_e     state;
  logic [2:0] opcode;
  logic       wrap_halt;
  logic       adv_go;

`ifdef FETCH_SINGLE_STEP_EN
  assign adv_go = bus.step;
  logic unused_ok;
  assign unused_ok = ^{bus.rom_data[5:0], opcode};
`else
  assign adv_go = 1'b1;
  logic unused_ok;
  assign unused_ok = ^{bus.rom_data[5:0], opcode, bus.step};
`endif

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state           <= IDLE;
      bus.ADDRESS     <= '0;
      bus.run         <= 1'b0;
      bus.busy        <= 1'b0;
      bus.halted      <= 1'b0;
      bus.instr_count <= '0;
      opcode          <= '0;
      wrap_halt       <= 1'b0;
    end else begin
      bus.run <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            state       <= WAIT_ROM;
            bus.ADDRESS <= '0;
            bus.busy    <= 1'b1;
          end
        end

        WAIT_ROM: begin
          state   <= ISSUE;
          bus.run <= 1'b1;
        end

        // rom_data is only valid during ISSUE, so the branch decodes it
        // directly rather than waiting a cycle for the latched copy.
        ISSUE: begin
          opcode <= bus.rom_data[8:6];
          if (bus.rom_data[8:6] == IMM_OPCODE) begin
            state <= IMM;
            if (bus.ADDRESS >= LAST_ADDR) begin
              bus.ADDRESS <= '0;
              wrap_halt   <= 1'b1;
            end else begin
              bus.ADDRESS <= bus.ADDRESS + 5'd1;
            end
          end else begin
            state <= EXEC;
          end
        end

        IMM: begin
          state <= EXEC;
        end

        EXEC: begin
          if (bus.done) begin
            if (bus.instr_count != 8'hFF)
              bus.instr_count <= bus.instr_count + 8'd1;
            if (wrap_halt) begin
              state      <= HALT;
              wrap_halt  <= 1'b0;
              bus.busy   <= 1'b0;
              bus.halted <= 1'b1;
            end else begin
              state <= ADVANCE;
            end
          end
        end

        ADVANCE: begin
          if (adv_go) begin
            if (bus.ADDRESS == LAST_ADDR) begin
              state      <= HALT;
              bus.busy   <= 1'b0;
              bus.halted <= 1'b1;
            end else begin
              state       <= WAIT_ROM;
              bus.ADDRESS <= bus.ADDRESS + 5'd1;
            end
          end
        end

        HALT: begin
          if (bus.start) begin
            state           <= WAIT_ROM;
            bus.ADDRESS     <= '0;
            bus.instr_count <= '0;
            bus.halted      <= 1'b0;
            bus.busy        <= 1'b1;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 The module SHALL have parameter LAST_ADDR, default 5'd31, meaning the final program-memory address; reaching it ends the program.
REQ-002 The module SHALL have parameter IMM_OPCODE, default 3'b001, meaning the opcode (data[8:6]) whose instruction carries one immediate word.
REQ-003 The module SHALL have port clk, input, 1 bit, meaning the single clock; all logic is rising-edge.
REQ-004 The module SHALL have port resetn, input, 1 bit, meaning synchronous, active-low reset.
REQ-005 The module SHALL have port start, input, 1 bit, meaning begin program execution from address 0.
REQ-006 The module SHALL have port step, input, 1 bit, meaning the single-step advance pulse (used only under REQ-027).
REQ-007 The module SHALL have port done, input, 1 bit, meaning the processor has completed the current instruction.
REQ-008 The module SHALL have port rom_data, input, 9 bits, meaning synchronous ROM output; it is valid one cycle after addr changes.
REQ-009 The module SHALL have port ADDRESS, output, 5 bits, meaning the ROM address.
REQ-010 The module SHALL have port run, output, 1 bit, meaning the instruction-start pulse to the processor.
REQ-011 The module SHALL have port busy, output, 1 bit, meaning the program is executing (any state other than IDLE or HALT).
REQ-012 The module SHALL have port halted, output, 1 bit, meaning the program has ended.
REQ-013 The module SHALL have port instr_count, output, 8 bits, meaning the count of completed instructions.

Function
REQ-014 The FSM SHALL have the states IDLE, WAIT_ROM, ISSUE, IMM, EXEC, ADVANCE and HALT, all registered.
REQ-015 In IDLE with start=1, the FSM SHALL go to WAIT_ROM with ADDRESS=0; start SHALL be ignored in every other state.
REQ-016 WAIT_ROM SHALL last exactly one cycle (ROM latency) and then go to ISSUE.
REQ-017 In ISSUE, run SHALL be 1 for exactly that one cycle, and opcode rom_data[8:6] SHALL be latched.
- If the latched opcode == IMM_OPCODE, the next state SHALL be IMM; otherwise it SHALL be EXEC.
REQ-018 On entry to IMM, ADDRESS SHALL be incremented by 1 so that the immediate word is on rom_data one cycle later; the FSM SHALL then go to EXEC.
REQ-019 In EXEC the FSM SHALL wait indefinitely for done=1.
- On done=1, instr_count SHALL increment (saturating at 8'hFF) and the FSM SHALL go to ADVANCE.
REQ-020 In ADVANCE:
- If ADDRESS == LAST_ADDR, the next state SHALL be HALT.
- Otherwise, ADDRESS SHALL be incremented by 1 and the next state SHALL be WAIT_ROM.
REQ-021 If the immediate increment in IMM would pass LAST_ADDR, ADDRESS SHALL wrap to 0, and after the resulting EXEC the FSM SHALL go to HALT.
REQ-022 HALT SHALL hold ADDRESS, with halted=1; start=1 in HALT SHALL clear halted, zero ADDRESS and instr_count, and go to WAIT_ROM.
REQ-023 run SHALL never be asserted outside ISSUE, and done SHALL be ignored outside EXEC.

Reset
REQ-024 While resetn=0 at a rising edge, the module SHALL set state=IDLE, ADDRESS=0, run=0, busy=0, halted=0, instr_count=0, and latched opcode=0.
REQ-025 Reset asserted in any state (including mid-EXEC) SHALL take effect at the next edge and SHALL abandon the current instruction without further run pulses.
REQ-026 Outputs SHALL be valid and at their reset values on the first cycle after resetn returns to 1.

Configuration
REQ-027 With macro FETCH_SINGLE_STEP_EN defined, ADVANCE SHALL additionally wait for step=1 before leaving ADVANCE.
- ADVANCE SHALL hold ADDRESS and busy=1 while waiting.
- A step pulse coincident with done=1 in EXEC SHALL NOT be retained.
REQ-028 Without FETCH_SINGLE_STEP_EN, the step input SHALL be ignored and ADVANCE SHALL last one cycle.

Verification
REQ-029 Reset then start=1 with ROM[0]=9'b000_001_010 and done returned 3 cycles after run: the bench SHALL check run high exactly in cycle 2 after start, ADDRESS 0->1, and instr_count=1.
REQ-030 ROM[0]=9'b001_000_000 (mvi), ROM[1]=9'h055: the bench SHALL check ADDRESS=1 in the cycle after run, the next instruction is fetched from ADDRESS=2, and exactly one run per instruction.
REQ-031 LAST_ADDR=3 with four non-immediate instructions: the bench SHALL check halted=1 and busy=0 after the fourth done, ADDRESS held at 3, and instr_count=4; start in HALT SHALL restart at ADDRESS=0.
REQ-032 resetn=0 asserted during EXEC: the bench SHALL check state IDLE, all outputs at reset values next cycle, and no run until a new start.
REQ-033 With FETCH_SINGLE_STEP_EN defined, the bench SHALL check that ADDRESS stays constant for 10 cycles after done until step=1, then advances by 1; without the macro, the same stimulus SHALL advance one cycle after done.
